// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: pipelined immediate generator for the decode stage.
// A beat is extended at accept time, then held in an output register (OR)
// backed by a one-entry skid register (SK). The registered in_ready signal
// means a stall from execute never reaches the producer combinationally.
// Optional build macro: IMM_ZIMM_EN. When it is defined, ImmSrc=101 selects
// the CSR zimm format. When it is not defined, 101 is treated as illegal.
module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      Imm,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  Imm_Ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);

  // One pipeline entry: the extended immediate, its tag and its illegal flag.
  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } beat_t;

  // Returns {illegal, immediate}. Imm[24] is instr[31], so it is the sign bit
  // for every signed format.
  function automatic logic [XLEN:0] extend_imm(input logic [24:0] imm,
                                               input logic [2:0]  src);
    logic [XLEN:0] res;
    logic          s;
    s = imm[24];
    case (src)
      3'b000:  res = {1'b0, {(XLEN-12){s}}, imm[24:13]};
      3'b001:  res = {1'b0, {(XLEN-12){s}}, imm[24:18], imm[4:0]};
      3'b010:  res = {1'b0, {(XLEN-12){s}}, imm[0], imm[23:18], imm[4:1], 1'b0};
      // imm[24] is bit 31 of the result, replicated above it on wide XLEN.
      3'b011:  res = {1'b0, {(XLEN-31){s}}, imm[23:5], 12'h000};
      3'b100:  res = {1'b0, {(XLEN-20){s}}, imm[12:5], imm[13], imm[23:14], 1'b0};
`ifdef IMM_ZIMM_EN
      3'b101:  res = {1'b0, {(XLEN-5){1'b0}}, imm[12:8]};
`else
      3'b101:  res = {1'b1, {XLEN{1'b0}}};
`endif
      default: res = {1'b1, {XLEN{1'b0}}};
    endcase
    return res;
  endfunction

  beat_t         or_beat_r;
  beat_t         sk_beat_r;
  logic          or_valid_r;
  logic          sk_valid_r;
  logic          in_ready_r;

  beat_t         new_beat_s;
  beat_t         or_beat_nxt_s;
  beat_t         sk_beat_nxt_s;
  logic          or_valid_nxt_s;
  logic          sk_valid_nxt_s;
  logic          accept_s;
  logic          or_load_s;
  logic [XLEN:0] ext_s;

  // Extend the incoming beat and decide whether the output register may load.
  always_comb begin
    ext_s           = extend_imm(Imm, ImmSrc);
    new_beat_s.data = ext_s[XLEN-1:0];
    new_beat_s.tag  = in_tag;
    new_beat_s.ill  = ext_s[XLEN];
    accept_s        = in_valid & in_ready_r;
    or_load_s       = ~or_valid_r | out_ready;
  end

  // Next-state steering between OR and SK. SK drains first to keep FIFO order.
  always_comb begin
    or_valid_nxt_s = or_valid_r;
    sk_valid_nxt_s = sk_valid_r;
    or_beat_nxt_s  = or_beat_r;
    sk_beat_nxt_s  = sk_beat_r;
    if (or_load_s) begin
      if (sk_valid_r) begin
        or_valid_nxt_s = 1'b1;
        or_beat_nxt_s  = sk_beat_r;
        sk_valid_nxt_s = accept_s;
        if (accept_s) begin
          sk_beat_nxt_s = new_beat_s;
        end else begin
          sk_beat_nxt_s = sk_beat_r;
        end
      end else begin
        or_valid_nxt_s = accept_s;
        sk_valid_nxt_s = 1'b0;
        if (accept_s) begin
          or_beat_nxt_s = new_beat_s;
        end else begin
          or_beat_nxt_s = or_beat_r;
        end
      end
    end else begin
      // OR is holding a stalled beat; an accepted beat parks in SK.
      if (accept_s) begin
        sk_valid_nxt_s = 1'b1;
        sk_beat_nxt_s  = new_beat_s;
      end else begin
        sk_valid_nxt_s = sk_valid_r;
      end
    end
  end

  // Pipeline state register: reset clears everything, flush kills valid bits only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      or_valid_r <= 1'b0;
      sk_valid_r <= 1'b0;
      in_ready_r <= 1'b1;
      or_beat_r  <= '0;
      sk_beat_r  <= '0;
    end else if (flush) begin
      or_valid_r <= 1'b0;
      sk_valid_r <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      or_valid_r <= or_valid_nxt_s;
      sk_valid_r <= sk_valid_nxt_s;
      in_ready_r <= ~sk_valid_nxt_s;
      or_beat_r  <= or_beat_nxt_s;
      sk_beat_r  <= sk_beat_nxt_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = or_valid_r;
  assign Imm_Ext   = or_beat_r.data;
  assign out_tag   = or_beat_r.tag;
  assign illegal   = or_beat_r.ill;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: a directed vector table, directed
// back-pressure / flush / reset sequences, and randomized traffic checked
// against a 2-deep queue model with arithmetic immediate decoding.
module tb_imm_extend_pipe;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [24:0]      imm_in;
  logic [2:0]       imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm_ext;
  logic [TAG_W-1:0] out_tag;
  logic             illegal;

  imm_extend_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .Imm(imm_in), .ImmSrc(imm_src), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .Imm_Ext(imm_ext), .out_tag(out_tag), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]  data;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [63:0] exp;
    logic        ill;
  } vec_t;

  exp_t model_q[$];
  int   total = 0;
  int   passed = 0;
  logic [31:0] cur_instr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference decode from the instruction word using signed arithmetic.
  function automatic exp_t ref_ext(input logic [31:0] instr, input logic [2:0] src,
                                   input logic [TAG_W-1:0] tag);
    exp_t        e;
    longint      v;
    logic [63:0] vv;
    logic        ill;
    ill = 1'b0;
    case (src)
      3'd0: v = longint'($signed(instr)) >>> 20;
      3'd1: v = ((longint'($signed(instr)) >>> 25) <<< 5) + longint'(instr[11:7]);
      3'd2: v = (instr[31] ? -64'sd4096 : 64'sd0) + (longint'(instr[7]) << 11)
                + (longint'(instr[30:25]) << 5) + (longint'(instr[11:8]) << 1);
      3'd3: v = longint'($signed(instr & 32'hFFFF_F000));
      3'd4: v = (instr[31] ? -64'sd1048576 : 64'sd0) + (longint'(instr[19:12]) << 12)
                + (longint'(instr[20]) << 11) + (longint'(instr[30:21]) << 1);
`ifdef IMM_ZIMM_EN
      3'd5: v = longint'(instr[19:15]);
`endif
      default: begin v = 64'sd0; ill = 1'b1; end
    endcase
    vv = v;
    e.data = vv[XLEN-1:0];
    e.tag  = tag;
    e.ill  = ill;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [2:0] src, input logic [31:0] instr,
                       input logic [TAG_W-1:0] tag, input logic ordy, input logic fl);
    in_valid  = v;
    imm_src   = src;
    cur_instr = instr;
    imm_in    = instr[31:7];
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Advance one clock: update the model at the edge, compare at the falling edge.
  task automatic tick();
    exp_t f;
    logic acc;
    @(posedge clk);
    if (!rst_n || flush) begin
      model_q.delete();
    end else begin
      acc = in_valid && (model_q.size() < 2);
      if (out_ready && model_q.size() > 0) void'(model_q.pop_front());
      if (acc) model_q.push_back(ref_ext(cur_instr, imm_src, in_tag));
    end
    @(negedge clk);
    check("in_ready", {63'd0, in_ready}, {63'd0, model_q.size() < 2});
    check("out_valid", {63'd0, out_valid}, {63'd0, model_q.size() > 0});
    if (model_q.size() > 0) begin
      f = model_q[0];
      check("imm_ext", 64'(imm_ext), 64'(f.data));
      check("out_tag", 64'(out_tag), 64'(f.tag));
      check("illegal", {63'd0, illegal}, {63'd0, f.ill});
    end
  endtask

  vec_t vecs[9];
  logic [XLEN-1:0] held;

  initial begin
    vecs[0] = '{32'hFFF0_0093, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[1] = '{32'h7FF0_0093, 3'b000, 64'h0000_0000_0000_07FF, 1'b0};
    vecs[2] = '{32'hFE00_0C23, 3'b001, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0};
    vecs[3] = '{32'hFE00_0EE3, 3'b010, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vecs[4] = '{32'h1234_50B7, 3'b011, 64'h0000_0000_1234_5000, 1'b0};
    vecs[5] = '{32'h0080_006F, 3'b100, 64'h0000_0000_0000_0008, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 3'b111, 64'h0000_0000_0000_0000, 1'b1};
    vecs[7] = '{32'hFFFF_FFFF, 3'b110, 64'h0000_0000_0000_0000, 1'b1};
`ifdef IMM_ZIMM_EN
    vecs[8] = '{32'h000F_8073, 3'b101, 64'h0000_0000_0000_001F, 1'b0};
`else
    vecs[8] = '{32'h000F_8073, 3'b101, 64'h0000_0000_0000_0000, 1'b1};
`endif

    // Reset state.
    rst_n = 1'b0;
    drive(1'b0, 3'b000, 32'd0, '0, 1'b1, 1'b0);
    tick();
    tick();
    check("rst_imm_ext", 64'(imm_ext), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_illegal", {63'd0, illegal}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Table: back-to-back formats, one result per cycle.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vecs[i].src, vecs[i].instr, TAG_W'(i + 10), 1'b1, 1'b0);
      tick();
      check("tbl_valid", {63'd0, out_valid}, 64'd1);
      check("tbl_imm", 64'(imm_ext), 64'(vecs[i].exp[XLEN-1:0]));
      check("tbl_ill", {63'd0, illegal}, {63'd0, vecs[i].ill});
      check("tbl_tag", 64'(out_tag), 64'(i + 10));
    end
    drive(1'b0, 3'b000, 32'd0, '0, 1'b1, 1'b0);
    tick();

    // Back-pressure: tags 1,2 accepted, tag 3 held upstream.
    drive(1'b1, 3'b000, 32'hABC0_0013, 5'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'b011, 32'h8765_4037, 5'd2, 1'b0, 1'b0);
    tick();
    check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    held = imm_ext;
    drive(1'b1, 3'b100, 32'h0080_006F, 5'd3, 1'b0, 1'b0);
    tick();
    tick();
    check("bp_stable_imm", 64'(imm_ext), 64'(held));
    check("bp_stable_tag", 64'(out_tag), 64'd1);
    out_ready = 1'b1;
    tick();
    check("bp_order2", 64'(out_tag), 64'd2);
    tick();
    check("bp_order3", 64'(out_tag), 64'd3);
    drive(1'b0, 3'b000, 32'd0, '0, 1'b1, 1'b0);
    tick();
    check("bp_drained", {63'd0, out_valid}, 64'd0);

    // Flush with both entries full and a beat on offer.
    drive(1'b1, 3'b000, 32'h0010_0093, 5'd4, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'b000, 32'h0020_0093, 5'd5, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'b000, 32'h0090_0093, 5'd9, 1'b0, 1'b1);
    tick();
    check("fl_out_valid", {63'd0, out_valid}, 64'd0);
    check("fl_in_ready", {63'd0, in_ready}, 64'd1);
    drive(1'b0, 3'b000, 32'd0, '0, 1'b1, 1'b0);
    tick();
    check("fl_no_ghost", {63'd0, out_valid}, 64'd0);

    // Reset while stalled with a valid output.
    drive(1'b1, 3'b111, 32'h0000_0000, 5'd6, 1'b0, 1'b0);
    tick();
    drive(1'b0, 3'b000, 32'd0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    check("mr_imm_ext", 64'(imm_ext), 64'd0);
    check("mr_out_tag", 64'(out_tag), 64'd0);
    check("mr_illegal", {63'd0, illegal}, 64'd0);
    rst_n = 1'b1;
    drive(1'b1, 3'b000, 32'hFFF0_0093, 5'd7, 1'b1, 1'b0);
    tick();
    check("mr_resume_tag", 64'(out_tag), 64'd7);
    drive(1'b0, 3'b000, 32'd0, '0, 1'b1, 1'b0);
    tick();

    // Randomized traffic against the queue model.
    for (int n = 0; n < 500; n++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom),
            TAG_W'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 29) == 0));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Pipelined, parametrised immediate generator for the decode stage.
- Accepts instruction bits [31:7] and an immediate-type select. Produces the sign- or zero-extended immediate at XLEN width.
- Supports I, S, B, U and J formats.
- Uses valid/ready handshakes on both sides, with a registered output stage and a 1-entry skid buffer, so decode back-pressure never forces a combinational ready path from execute.

Parameters:
- XLEN, 32, output width; legal values 32 or 64. Sign extension fills XLEN bits.
- TAG_W, 5, width of the sideband tag (e.g. rd/ROB index) carried with each immediate.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  synchronous pipeline kill
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat; registered
- Imm  in  25  instruction bits [31:7] (Imm[24] = instr[31])
- ImmSrc  in  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (optional), 110/111 illegal
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts output
- Imm_Ext  out  XLEN  extended immediate
- out_tag  out  TAG_W  tag aligned with Imm_Ext
- illegal  out  1  ImmSrc was illegal for this beat

Behaviour:
- Formats, with S = Imm[24] replicated to XLEN:
  - I: S,Imm[24:13]
  - S: S,Imm[24:18],Imm[4:0]
  - B: S,Imm[0],Imm[23:18],Imm[4:1],0
  - U: S,Imm[24:5],12'b0 (upper bits sign-extended when XLEN=64)
  - J: S,Imm[12:5],Imm[13],Imm[23:14],0
- Illegal ImmSrc: Imm_Ext=0, illegal=1. The beat still flows through the pipe; it is never dropped.
- Storage: output register (OR) plus skid register (SK), each with a valid bit.
- Accept: a beat is accepted when in_valid & in_ready. Extension is computed combinationally at accept.
- Output update:
  - OR loads if OR is empty or out_ready=1.
  - Otherwise the beat goes to SK.
- Skid drain: when out_ready=1 and SK is valid, SK moves into OR. A beat accepted in the same cycle then lands in SK, or in OR if SK was empty.
- Latency: 1 cycle from accept to out_valid when the pipe is empty.
- in_ready = ~SK.valid, registered. When SK fills, in_ready deasserts the next cycle.
- Ordering: strictly FIFO order, no reordering.
- Output stability: while out_valid=1 and out_ready=0, Imm_Ext, out_tag and illegal hold stable.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Reset (rst_n=0 at a clk edge):
  - OR.valid=0, SK.valid=0, out_valid=0, in_ready=1, Imm_Ext=0, out_tag=0, illegal=0.
  - Reset applied mid-stream discards all held beats.
- Flush:
  - Clears OR.valid and SK.valid at the edge; in_ready=1 the next cycle.
  - A beat presented in the flush cycle is discarded; flush has priority over accept.
  - Data registers need not clear.
- Full and empty:
  - Both entries full: in_ready=0. Input is ignored even if in_valid=1.
  - Empty: out_valid=0. out_ready is don't-care.

Optional Feature:
- Macro: IMM_ZIMM_EN.
- Defined: ImmSrc=101 selects the CSR zimm format. Imm_Ext = zero-extended Imm[12:8] (instr[19:15]), illegal=0.
- Undefined: 101 is treated as illegal (Imm_Ext=0, illegal=1).

Test Plan:
- Reset, then I-type: Imm=0xFFF00093>>7, ImmSrc=000, out_ready=1 -> next cycle out_valid=1, Imm_Ext=0xFFFFFFFF, illegal=0. With XLEN=64, Imm_Ext=0xFFFFFFFFFFFFFFFF.
- Back-to-back formats, out_ready=1, each Imm = instr>>7:
  - B: instr 0xFE000EE3, ImmSrc=010 -> Imm_Ext=0xFFFFFFFC.
  - U: instr 0x123450B7, ImmSrc=011 -> Imm_Ext=0x12345000.
  - J: instr 0x0080006F, ImmSrc=100 -> Imm_Ext=0x00000008.
  - Check one result per cycle, in order, tags matching.
- Back-pressure:
  - Hold out_ready=0 and send tags 1,2,3 -> tags 1,2 accepted; in_ready=0 from the cycle after tag 2; tag 3 is held upstream.
  - Release out_ready -> outputs arrive in order 1,2,3 with no loss or duplicates, and Imm_Ext is stable while stalled.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the beat offered in the flush cycle never appears at the output.
- ImmSrc=111 -> Imm_Ext=0, illegal=1. ImmSrc=101 with instr[19:15]=0x1F -> Imm_Ext=0x1F when IMM_ZIMM_EN is defined; Imm_Ext=0, illegal=1 when it is not.
- Assert rst_n=0 for one cycle while out_valid=1 and out_ready=0 -> all outputs at reset values the next cycle; the pipe accepts normally afterwards.
